soc_system_cpu_cpu_div_cell: RTL and testbench
==============================================

// Module: soc_system_cpu_cpu_div_cell
// PURPOSE
//  Iterative radix-2 restoring divider for the CPU execute stage; the inverse of the
//  pipelined partial-product multiplier. Takes E-stage operands on a start pulse,
//  iterates one quotient bit per clock, returns quotient and remainder with a one-cycle
//  valid strobe. Signed (truncate toward zero) or unsigned per operation.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits (even, >= 8)
// PORTS
//  clk            in   1      sole clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high reset
//  E_src1         in   WIDTH  dividend, sampled on accepted start
//  E_src2         in   WIDTH  divisor, sampled on accepted start
//  E_div_signed   in   1      1 = two's-complement operands, 0 = unsigned; sampled with start
//  E_div_start    in   1      request; accepted only when div_busy = 0
//  div_busy       out  1      high while an operation is in flight (state != IDLE)
//  div_valid      out  1      one-cycle strobe: quotient/remainder valid this cycle
//  div_quotient   out  WIDTH  quotient; holds until next accepted start
//  div_remainder  out  WIDTH  remainder, sign of dividend; holds until next accepted start
// BEHAVIOUR
//  - Reset: state IDLE; div_busy=0, div_valid=0, div_quotient=0, div_remainder=0, counter=0.
//    Reset mid-operation abandons it; no div_valid is produced for it.
//  - States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
//    IDLE: E_div_start=1 captures operands and sign mode, -> PREP.
//    PREP: form |dividend|, |divisor| (signed mode), record q_neg = sign1^sign2, r_neg = sign1;
//      clear partial remainder, load counter = WIDTH-1; -> ITER.
//    ITER: shift {rem,dvd} left 1; trial = rem - divisor (WIDTH+1 bits); if trial >= 0 keep
//      trial, quotient bit = 1, else bit = 0. Counter decrements; at 0 -> FIX. WIDTH clocks.
//    FIX: negate quotient if q_neg, remainder if r_neg; register outputs; -> DONE.
//    DONE: div_valid=1 for this cycle only; -> IDLE.
//  - Latency: div_valid high WIDTH+3 clocks after the edge sampling start (35 for WIDTH=32).
//  - E_div_start while div_busy=1 (including DONE cycle) is ignored, not queued.
//  - Divide by zero: quotient = all ones, remainder = dividend (both modes); falls out of
//    the iteration naturally, no special state.
//  - Signed overflow (-2^(WIDTH-1) / -1): quotient = 0x80000000, remainder = 0 (WIDTH=32).
//  - |most-negative| treated as unsigned 2^(WIDTH-1) in PREP; no saturation.
//  - div_quotient/div_remainder update only in FIX; stable otherwise.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: PREP detects divisor==0, or unsigned |dividend| < |divisor|;
//    skips ITER, loads result directly (zero: q=all ones, r=dividend; small: q=0,
//    r=dividend), -> DONE. div_valid 3 clocks after start edge for these cases.
//  DIV_EARLY_OUT_EN undefined: every operation takes the full WIDTH+3 latency; no compare logic.
// TESTING
//  1 unsigned 100/7 -> q=14, r=2, div_valid exactly 35 clocks after start, busy high throughout.
//  2 signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
//  3 0x12345678/0 (both modes) -> q=0xFFFFFFFF, r=0x12345678; early-out build: valid at 3 clocks.
//  4 signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned same -> q=0, r=0x80000000.
//  5 second start 5 clocks after first -> ignored; one div_valid, results of first op only.
//  6 reset asserted at clock 10 of an op -> next cycle busy=0, valid=0, outputs 0; no strobe later;
//    new start afterwards completes normally (1000/10 -> q=100, r=0).

Source files
------------

// File: rtl/soc_system_cpu_cpu_div_cell_if.sv
// Operand/result bundle between the execute stage and the iterative divider.
interface soc_system_cpu_cpu_div_cell_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] E_src1;
    logic [WIDTH-1:0] E_src2;
    logic             E_div_signed;
    logic             E_div_start;
    logic             div_busy;
    logic             div_valid;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    modport master (
        output E_src1, E_src2, E_div_signed, E_div_start,
        input  div_busy, div_valid, div_quotient, div_remainder
    );

    modport slave (
        input  E_src1, E_src2, E_div_signed, E_div_start,
        output div_busy, div_valid, div_quotient, div_remainder
    );
endinterface

// File: rtl/soc_system_cpu_cpu_div_cell.sv
// Iterative radix-2 restoring divider, signed (truncate toward zero) or unsigned.
// Optional DIV_EARLY_OUT_EN: zero divisor or small dividend bypasses the iteration.
module soc_system_cpu_cpu_div_cell #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    soc_system_cpu_cpu_div_cell_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, valid_q, valid_d;
    logic [WIDTH-1:0] qout_q, qout_d, rout_q, rout_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, trial;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
        end
    end

    // Next-state, iteration step and result fix-up
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        qout_d  = qout_q;
        rout_d  = rout_q;

        sign_a  = sgn_q & a_q[WIDTH-1];
        sign_b  = sgn_q & b_q[WIDTH-1];
        abs_a   = sign_a ? ('0 - a_q) : a_q;
        abs_b   = sign_b ? ('0 - b_q) : b_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};

        case (state_q)
            S_IDLE: begin
                if (bus.E_div_start) begin
                    a_d     = bus.E_src1;
                    b_d     = bus.E_src2;
                    sgn_d   = bus.E_div_signed;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                quo_d   = abs_a;
                dsr_d   = abs_b;
                rem_d   = '0;
                // A zero divisor keeps the all-ones quotient regardless of dividend sign
                q_neg_d = (sign_a ^ sign_b) & (abs_b != '0);
                r_neg_d = sign_a;
                cnt_d   = CW'(WIDTH - 1);
                state_d = S_ITER;
`ifdef DIV_EARLY_OUT_EN
                if (abs_b == '0) begin
                    quo_d   = '1;
                    rem_d   = abs_a;
                    state_d = S_FIX;
                end else if (abs_a < abs_b) begin
                    quo_d   = '0;
                    rem_d   = abs_a;
                    state_d = S_FIX;
                end
`endif
            end
            S_ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                qout_d  = q_neg_q ? ('0 - quo_q) : quo_q;
                rout_d  = r_neg_q ? ('0 - rem_q) : rem_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    assign bus.div_busy      = busy_q;
    assign bus.div_valid     = valid_q;
    assign bus.div_quotient  = qout_q;
    assign bus.div_remainder = rout_q;
endmodule

// File: tb/tb_soc_system_cpu_cpu_div_cell.sv
// Directed bench for the iterative divider: latency, sign handling, corner cases, reset abort.
module tb_soc_system_cpu_cpu_div_cell;
    localparam int unsigned WIDTH = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int SHORT_LAT = 3;
`else
    localparam int SHORT_LAT = 35;
`endif
    localparam int FULL_LAT = 35;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    soc_system_cpu_cpu_div_cell_if #(.WIDTH(WIDTH)) bus ();

    soc_system_cpu_cpu_div_cell #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation and follows it to its valid strobe
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sgn, input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                          input int exp_lat);
        int  n;
        logic busy_ok;
        @(negedge clk);
        bus.E_src1       = a;
        bus.E_src2       = b;
        bus.E_div_signed = sgn;
        bus.E_div_start  = 1'b1;
        @(posedge clk);
        n       = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            bus.E_div_start = 1'b0;
            n++;
            if (bus.div_busy !== 1'b1) busy_ok = 1'b0;
        end while (bus.div_valid !== 1'b1 && n < 200);
        check({tag, "_lat"}, WIDTH'(n), WIDTH'(exp_lat));
        check({tag, "_busy"}, WIDTH'(busy_ok), WIDTH'(1));
        check({tag, "_q"}, bus.div_quotient, exp_q);
        check({tag, "_r"}, bus.div_remainder, exp_r);
        @(negedge clk);
        check({tag, "_strobe"}, WIDTH'(bus.div_valid), WIDTH'(0));
    endtask

    initial begin
        int n;
        int strobes;
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.E_src1       = '0;
        bus.E_src2       = '0;
        bus.E_div_signed = 1'b0;
        bus.E_div_start  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", WIDTH'(bus.div_busy), WIDTH'(0));
        check("rst_valid", WIDTH'(bus.div_valid), WIDTH'(0));
        check("rst_q", bus.div_quotient, '0);
        check("rst_r", bus.div_remainder, '0);

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, FULL_LAT);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, FULL_LAT);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, FULL_LAT);
        run_op("u_div0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, SHORT_LAT);
        run_op("s_div0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, SHORT_LAT);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, FULL_LAT);
        run_op("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, SHORT_LAT);

        // Start pulse while busy must be dropped
        @(negedge clk);
        bus.E_src1       = 32'd100;
        bus.E_src2       = 32'd7;
        bus.E_div_signed = 1'b0;
        bus.E_div_start  = 1'b1;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        repeat (4) @(negedge clk);
        bus.E_src1      = 32'd200;
        bus.E_src2      = 32'd3;
        bus.E_div_start = 1'b1;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.div_valid === 1'b1) begin
                strobes++;
                check("ign_q", bus.div_quotient, 32'd14);
                check("ign_r", bus.div_remainder, 32'd2);
            end
        end
        check("ign_strobes", WIDTH'(strobes), WIDTH'(1));

        // Reset partway through an operation abandons it
        @(negedge clk);
        bus.E_src1      = 32'd1000;
        bus.E_src2      = 32'd3;
        bus.E_div_start = 1'b1;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", WIDTH'(bus.div_busy), WIDTH'(0));
        check("abort_valid", WIDTH'(bus.div_valid), WIDTH'(0));
        check("abort_q", bus.div_quotient, '0);
        check("abort_r", bus.div_remainder, '0);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.div_valid === 1'b1) n++;
        end
        check("abort_nostrobe", WIDTH'(n), WIDTH'(0));
        run_op("post_rst", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, FULL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
